// File: rtl/crc16_calc.sv
// Bit-serial CRC-16 generator: takes bytes over valid/ready, shifts each MSB-first
// through a 16-bit LFSR, and publishes the checksum with a one-cycle crc_rdy strobe.
module crc16_calc #(
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] INIT   = 16'hFFFF,
  parameter logic [15:0] XOROUT = 16'h0000
) (
  input  logic        clk50m,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        data_last,
  output logic        data_ready,
  output logic        busy,
  output logic [15:0] crc_calc,
  output logic        crc_rdy
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BYTE = 2'd1;
  localparam logic [1:0] S_SHIFT     = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  logic [1:0]  state_q,  state_d;
  logic [15:0] lfsr_q,   lfsr_d;
  logic [7:0]  shreg_q,  shreg_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        last_q,   last_d;
  logic [15:0] crc_q,    crc_d;
  logic        rdy_q,    rdy_d;

  logic        fb;
  logic [15:0] lfsr_step;

  assign fb        = lfsr_q[15] ^ shreg_q[7];
  assign lfsr_step = {lfsr_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    last_d   = last_q;
    crc_d    = crc_q;
    rdy_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lfsr_d  = INIT;
          state_d = S_WAIT_BYTE;
        end
      end
      S_WAIT_BYTE: begin
        if (data_valid) begin
          shreg_d  = data_in;
          last_d   = data_last;
          bitcnt_d = 3'd0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        lfsr_d   = lfsr_step;
        shreg_d  = {shreg_q[6:0], 1'b0};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          if (last_q) begin
            // Publish the value the LFSR takes on this edge, i.e. after the final bit.
            crc_d   = lfsr_step ^ XOROUT;
            rdy_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_BYTE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= INIT;
      shreg_q  <= 8'h00;
      bitcnt_q <= 3'd0;
      last_q   <= 1'b0;
      crc_q    <= 16'h0000;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      last_q   <= last_d;
      crc_q    <= crc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_ready = (state_q == S_WAIT_BYTE);
  assign busy       = (state_q != S_IDLE);
  assign crc_calc   = crc_q;
  assign crc_rdy    = rdy_q;

endmodule

// File: tb/tb_crc16_calc.sv
// Self-checking bench for crc16_calc: vector table of frames plus hand-written
// sequences for stalls, ignored start, back-to-back frames and mid-frame reset.
module tb_crc16_calc;

  logic        clk50m = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_last;
  logic        data_ready;
  logic        busy;
  logic [15:0] crc_calc;
  logic        crc_rdy;

  crc16_calc dut (
    .clk50m     (clk50m),
    .rst_n      (rst_n),
    .start      (start),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_last  (data_last),
    .data_ready (data_ready),
    .busy       (busy),
    .crc_calc   (crc_calc),
    .crc_rdy    (crc_rdy)
  );

  always #5 clk50m = ~clk50m;

  typedef struct {
    logic [7:0]  b [16];
    int          len;
    logic [15:0] exp;
    int          max_gap;
    bit          junk;
  } vec_t;

  typedef struct {
    logic [15:0] crc;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[5];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          hs_cnt = 0;
  logic        prev_rdy = 1'b0;
  logic [15:0] prev_crc = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference CRC-16/CCITT-FALSE, computed bit by bit from the polynomial definition.
  function automatic logic [15:0] crc_model(input vec_t v);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < v.len; i++) begin
      c = c ^ {v.b[i], 8'h00};
      for (int k = 0; k < 8; k++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  always @(posedge clk50m) cyc++;

  // Output monitor: pops the scoreboard on every crc_rdy.
  always @(negedge clk50m) begin
    exp_t e;
    if (data_valid && data_ready) hs_cnt++;
    if (crc_rdy) begin
      check("rdy_one_cycle", 32'(prev_rdy), 32'd0);
      check("unexpected_crc_rdy", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("crc_value", 32'(crc_calc), 32'(e.crc));
        check("crc_latency", 32'(cyc), 32'(e.cyc));
      end
    end else if (rst_n) begin
      check("crc_hold", 32'(crc_calc), 32'(prev_crc));
    end
    prev_rdy = crc_rdy;
    prev_crc = crc_calc;
  end

  task automatic send_byte(input logic [7:0] b, input bit last, input int gap,
                           input bit junk, output int acc);
    int t;
    if (junk) begin
      data_valid = 1'b1; data_in = ~b; data_last = 1'b1;
      @(posedge clk50m); #1;
      data_valid = 1'b0; data_last = 1'b0;
    end
    repeat (gap) begin @(posedge clk50m); #1; end
    data_valid = 1'b1; data_in = b; data_last = last;
    t = 0;
    @(negedge clk50m);
    while (!data_ready && t < 30) begin @(negedge clk50m); t++; end
    check("ready_wait", 32'(data_ready), 32'd1);
    @(posedge clk50m); #1;
    acc = cyc;
    data_valid = 1'b0; data_last = 1'b0; data_in = 8'h00;
  endtask

  task automatic wait_done(input int hs0, input int len);
    int t = 0;
    while (sb.size() != 0 && t < 40) begin @(posedge clk50m); t++; end
    check("frame_done_timeout", 32'(sb.size()), 32'd0);
    #1;
    check("bytes_consumed", 32'(hs_cnt - hs0), 32'(len));
  endtask

  task automatic send_frame(input vec_t v);
    int hs0, acc, gap;
    hs0 = hs_cnt;
    start = 1'b1;
    @(posedge clk50m); #1;
    start = 1'b0;
    for (int i = 0; i < v.len; i++) begin
      gap = (v.max_gap > 0) ? int'($urandom_range(0, v.max_gap)) : 0;
      send_byte(v.b[i], i == v.len - 1, gap, v.junk && i > 0, acc);
    end
    sb.push_back('{crc: v.exp, cyc: acc + 8});
    wait_done(hs0, v.len);
  endtask

  initial begin
    int acc, hs0;
    logic [7:0] digits [9];

    for (int i = 0; i < 9; i++) digits[i] = 8'h31 + 8'(i);
    foreach (vecs[i]) begin
      vecs[i].len = 0; vecs[i].max_gap = 0; vecs[i].junk = 1'b0; vecs[i].exp = 16'h0;
      for (int k = 0; k < 16; k++) vecs[i].b[k] = 8'h00;
    end
    vecs[0].b[0] = 8'h41; vecs[0].len = 1; vecs[0].exp = 16'hB915;
    for (int k = 0; k < 9; k++) vecs[1].b[k] = digits[k];
    vecs[1].len = 9; vecs[1].exp = 16'h29B1;
    vecs[2] = vecs[1]; vecs[2].max_gap = 5; vecs[2].junk = 1'b1;
    vecs[3].b[0] = 8'h00; vecs[3].len = 1; vecs[3].exp = 16'hE1F0;
    for (int k = 0; k < 6; k++) vecs[4].b[k] = 8'($urandom);
    vecs[4].len = 6; vecs[4].max_gap = 3; vecs[4].junk = 1'b1;
    vecs[4].exp = crc_model(vecs[4]);

    // Reset state
    rst_n = 1'b0; start = 1'b0; data_in = 8'h00; data_valid = 1'b0; data_last = 1'b0;
    #3;
    check("rst_crc_calc", 32'(crc_calc), 32'h0);
    check("rst_crc_rdy", 32'(crc_rdy), 32'd0);
    check("rst_data_ready", 32'(data_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk50m);
    #1 rst_n = 1'b1;

    // data_valid in IDLE is ignored
    data_valid = 1'b1; data_in = 8'h55; data_last = 1'b1;
    repeat (3) begin @(posedge clk50m); #1; end
    data_valid = 1'b0; data_last = 1'b0;
    check("idle_valid_ignored_hs", 32'(hs_cnt), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Table-driven frames
    foreach (vecs[i]) send_frame(vecs[i]);

    // Ignored start during WAIT_BYTE and SHIFT, then back-to-back frame at A+10
    hs0 = hs_cnt;
    start = 1'b1; @(posedge clk50m); #1; start = 1'b0;
    start = 1'b1; @(posedge clk50m); #1; start = 1'b0;
    check("wait_start_ignored_ready", 32'(data_ready), 32'd1);
    check("wait_start_ignored_busy", 32'(busy), 32'd1);
    send_byte(8'h41, 1'b1, 0, 1'b0, acc);
    sb.push_back('{crc: 16'hB915, cyc: acc + 8});
    start = 1'b1; @(posedge clk50m); #1; start = 1'b0;
    wait_done(hs0, 1);
    check("b2b_idle", 32'(busy), 32'd0);
    check("b2b_hold_before_next", 32'(crc_calc), 32'hB915);
    send_frame(vecs[1]);

    // Reset during SHIFT of byte 4, then a fresh "A" frame
    start = 1'b1; @(posedge clk50m); #1; start = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(digits[i], 1'b0, 0, 1'b0, acc);
    repeat (3) @(posedge clk50m);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_crc_calc", 32'(crc_calc), 32'h0);
    check("midrst_crc_rdy", 32'(crc_rdy), 32'd0);
    check("midrst_data_ready", 32'(data_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk50m);
    #1 rst_n = 1'b1;
    repeat (15) @(posedge clk50m);
    #1;
    send_frame(vecs[0]);

    repeat (5) @(posedge clk50m);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/crc16_calc.md
# crc16_calc

Bit-serial CRC-16 generator that sits directly upstream of the CRC comparator. It accepts a frame of payload bytes over a valid/ready handshake and shifts each byte MSB-first through a 16-bit LFSR, one bit per clock. After the last byte it presents the finished checksum on `crc_calc` with a one-cycle `crc_rdy` strobe. The comparator samples that strobe to check the result against the received hash.

## Interface
- `POLY`, default 16'h1021, generator polynomial (x^16 term implicit).
- `INIT`, default 16'hFFFF, LFSR value loaded on `start`.
- `XOROUT`, default 16'h0000, value XORed onto the LFSR when the result is published.
- `clk50m`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a new frame; sampled only in IDLE.
- `data_in`  in  8  payload byte.
- `data_valid`  in  1  `data_in` / `data_last` are valid.
- `data_last`  in  1  the current byte is the final byte of the frame.
- `data_ready`  out  1  block can accept a byte this cycle.
- `busy`  out  1  high in every state except IDLE.
- `crc_calc`  out  16  finished CRC; holds until the next frame completes.
- `crc_rdy`  out  1  one-cycle strobe; `crc_calc` is valid in the same cycle.

## Operation
- States: IDLE, WAIT_BYTE, SHIFT, DONE.
- **IDLE**
  - `start`=1: lfsr <= `INIT`, go to WAIT_BYTE.
  - `data_valid` in IDLE is ignored; no byte is consumed.
- **WAIT_BYTE**
  - `data_ready`=1 (combinational decode of the state).
  - On `data_valid`=1: latch `data_in` into shreg and `data_last` into last_q, bitcnt <= 0, go to SHIFT.
- **SHIFT**
  - Each cycle: fb = lfsr[15] ^ shreg[7]; lfsr <= {lfsr[14:0],1'b0} ^ (fb ? `POLY` : 0); shreg <= shreg << 1; bitcnt <= bitcnt+1.
  - bitcnt is 3 bits. Its wrap from 7 to 0 marks the end of the byte.
  - At bitcnt==7: go to DONE if last_q=1, else go to WAIT_BYTE.
- **DONE**
  - Exactly one cycle, then go to IDLE.
  - On entry, `crc_calc` <= lfsr ^ `XOROUT` and `crc_rdy` <= 1 (registered).
- Non-reflected input and output (CRC-16/CCITT-FALSE with the default parameters).
- `start` outside IDLE is ignored. Restarting a frame requires either reaching IDLE or asserting reset.
- A zero-length frame is not supported: every frame carries at least one byte with `data_last`=1.
- Reset (any state, any cycle, including mid-SHIFT):
  - state = IDLE; lfsr = `INIT`; shreg = 0; bitcnt = 0; last_q = 0.
  - `crc_calc` = 16'h0000; `crc_rdy` = 0; `data_ready` = 0; `busy` = 0.
  - The partial frame is discarded and no `crc_rdy` is produced for it.

## Timing
- `start` sampled at edge E0: WAIT_BYTE from E0; `data_ready`=1 in the cycle after E0.
- Byte accepted at edge A:
  - SHIFT occupies the cycles following edges A through A+7.
  - If the byte is not the last, WAIT_BYTE follows edge A+8.
- Byte throughput: at most one byte per 9 cycles with `data_valid` held high continuously.
- Last byte accepted at edge A: `crc_rdy`=1 and the new `crc_calc` are visible in the cycle after edge A+8.
  - `crc_rdy` returns to 0 after edge A+9.
  - IDLE after edge A+9; a `start` may be sampled at edge A+10.
- `crc_rdy` is never high for two consecutive cycles.
- `crc_calc` changes only on the edge that raises `crc_rdy`, or on reset.
- `data_ready` is 0 in IDLE, SHIFT and DONE. A `data_valid` pulse in those states is dropped; the upstream source must hold the byte until it sees `data_ready`.

## Test plan
- Reset values: assert `rst_n`=0 asynchronously mid-cycle -> all outputs 0 immediately, state IDLE, and no `crc_rdy` afterwards.
- Single byte: `start`, then 0x41 with `data_last`=1 -> `crc_calc`=16'hB915 and `crc_rdy` one cycle high, 9 cycles after acceptance.
- Standard check value: `start`, then ASCII "123456789" (0x31..0x39, `data_last` on 0x39) -> `crc_calc`=16'h29B1.
- Handshake stalls: the same "123456789" frame with random 0–5 cycle gaps on `data_valid`, and `data_valid` pulses in SHIFT that must be ignored -> still 16'h29B1 and exactly 9 bytes consumed.
- Reset mid-frame: assert reset during the SHIFT of byte 4 of "123456789", then run a fresh "A" frame -> no `crc_rdy` for the aborted frame; the fresh frame gives 16'hB915.
- Back-to-back frames plus ignored `start`: pulse `start` during WAIT_BYTE of an "A" frame -> ignored, result 16'hB915. Then issue `start` at A+10 for "123456789" -> 16'h29B1; `crc_calc` holds 16'hB915 until then.
